pipelined_csa_adder: RTL and testbench
======================================

PIPELINED_CSA_ADDER -- requirements
Module: pipelined_csa_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter BLOCK, default 4, carry-select block width in bits.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (asynchronous active-low reset).
REQ-004 SHALL have in_valid input 1, meaning the input operands are valid.
REQ-005 SHALL have in_ready output 1, meaning the adder accepts an operand set this cycle.
REQ-006 SHALL have a input WIDTH, operand A.
REQ-007 SHALL have b input WIDTH, operand B.
REQ-008 SHALL have cin input 1, carry into bit 0.
REQ-009 SHALL have out_valid output 1, meaning the result is valid.
REQ-010 SHALL have out_ready input 1, meaning the consumer accepts the result.
REQ-011 SHALL have sum output WIDTH, result bits.
REQ-012 SHALL have cout output 1, carry out of bit WIDTH-1.
REQ-013 SHALL have ovf output 1, signed overflow, present only under CSA_OVF_EN.

Function
REQ-014 SHALL compute {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), for every accepted transfer.
REQ-015 SHALL accept an operand set only when in_valid and in_ready are both 1 at a rising edge.
REQ-016 SHALL deliver a result only when out_valid and out_ready are both 1 at a rising edge.
REQ-017 SHALL use two pipeline stages, with latency exactly 2 cycles from acceptance to out_valid when there is no backpressure.
REQ-018 SHALL, in stage 1, split the operands into WIDTH/BLOCK blocks and register per block the sum and carry for an assumed carry-in of 0 and of 1; block 0 SHALL use the real cin.
REQ-019 SHALL, in stage 2, resolve the block carries with a select-mux chain from block 0 upward and register sum and cout.
REQ-020 SHALL advance each stage when it is empty or when the stage after it advances in the same cycle; in_ready = !s1_valid | s1_advance.
REQ-021 SHALL sustain one result per cycle at full throughput (in_valid=1, out_ready=1).
REQ-022 SHALL hold sum, cout and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL allow a new input to be accepted in the same cycle the output is accepted when the pipeline is full, with no bubble and no loss.
REQ-024 SHALL drive in_ready=0 when both stages are valid and out_ready=0.
REQ-025 SHALL reject WIDTH not divisible by BLOCK, or BLOCK<1, at elaboration.

Reset
REQ-026 SHALL, while rst_n=0, immediately clear both stage valid flags; out_valid=0, sum=0, cout=0 and ovf=0.
REQ-027 SHALL discard any in-flight transfers on a reset asserted mid-operation; no result SHALL appear after reset release.
REQ-028 SHALL assert in_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-029 SHALL, when macro CSA_OVF_EN is defined, provide port ovf = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]), registered and pipelined alongside sum.
REQ-030 SHALL, when CSA_OVF_EN is undefined, omit port ovf and all of its logic; all other behaviour SHALL be identical.

Structure
REQ-031 SHALL keep CSA_DEFAULT_WIDTH=32 and CSA_DEFAULT_BLOCK=4 in shared package csa_pkg.
REQ-032 SHALL instantiate sub-module csa_block once per block: a BLOCK-bit dual ripple adder producing sum0/c0 and sum1/c1.

Verification
REQ-033 SHALL test a basic add: WIDTH=32, a=0x0000_0001, b=0x0000_0002, cin=0 -> sum=0x0000_0003, cout=0, out_valid exactly 2 cycles after acceptance.
REQ-034 SHALL test a full carry chain: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1; with CSA_OVF_EN, ovf=0.
REQ-035 SHALL test signed overflow with CSA_OVF_EN: a=0x7FFF_FFFF, b=0x0000_0001, cin=0 -> sum=0x8000_0000, ovf=1, cout=0.
REQ-036 SHALL test backpressure: send 3 back-to-back inputs with out_ready=0 -> in_ready falls after 2 accepts and outputs are held stable; then raise out_ready -> 3 results in order with no loss.
REQ-037 SHALL test reset mid-flight: pull rst_n low with 2 transfers in flight -> out_valid=0 at once, and no result appears after release.
REQ-038 SHALL run 10,000 random streams with WIDTH=16, BLOCK=4 and with WIDTH=8, BLOCK=8, with random valid/ready toggling -> all results match a+b+cin and arrive in order.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared definitions for the pipelined carry-select adder.
// Optional feature: define CSA_OVF_EN to add the signed-overflow output.
package csa_pkg;

    localparam int CSA_DEFAULT_WIDTH = 32;
    localparam int CSA_DEFAULT_BLOCK = 4;

    // Number of carry-select blocks; a bad BLOCK is flagged elsewhere, so
    // this only has to avoid dividing by zero while that happens.
    function automatic int csa_num_blocks(input int width, input int block);
        if (block < 1) begin
            return 1;
        end
        return (width / block > 0) ? width / block : 1;
    endfunction

endpackage

// File: rtl/csa_block.sv
// One carry-select block: two BLOCK-bit ripple adders evaluated in parallel,
// one for each assumed carry-in, so the real carry only has to pick a result.
module csa_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin0,
    input  logic             cin1,
    output logic [BLOCK-1:0] sum0,
    output logic [BLOCK-1:0] sum1,
    output logic             c0,
    output logic             c1
);

    // Two independent bit-serial ripple chains, one per assumed carry-in.
    always_comb begin
        logic carry0;
        logic carry1;
        sum0   = '0;
        sum1   = '0;
        carry0 = cin0;
        carry1 = cin1;
        for (int i = 0; i < BLOCK; i++) begin
            sum0[i] = a[i] ^ b[i] ^ carry0;
            sum1[i] = a[i] ^ b[i] ^ carry1;
            carry0  = (a[i] & b[i]) | (carry0 & (a[i] ^ b[i]));
            carry1  = (a[i] & b[i]) | (carry1 & (a[i] ^ b[i]));
        end
        c0 = carry0;
        c1 = carry1;
    end

endmodule

// File: rtl/pipelined_csa_adder.sv
// Two-stage pipelined carry-select adder with valid/ready handshakes.
// Stage 1 registers both candidate sums/carries of every block; stage 2
// resolves the block carries with a mux chain and registers the result.
// Optional feature: define CSA_OVF_EN to add the registered ovf output.
module pipelined_csa_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_DEFAULT_WIDTH,
    parameter int BLOCK = CSA_DEFAULT_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CSA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NB = csa_num_blocks(WIDTH, BLOCK);

    // Refuse configurations that cannot be split into whole blocks.
    generate
        if (BLOCK < 1) begin : g_bad_block
            $error("pipelined_csa_adder: BLOCK must be at least 1");
        end else if ((WIDTH % ((BLOCK < 1) ? 1 : BLOCK)) != 0) begin : g_bad_width
            $error("pipelined_csa_adder: WIDTH must be a multiple of BLOCK");
        end
    endgenerate

    // Block adder outputs (combinational, from the raw operands)
    logic [WIDTH-1:0] blk_sum0;
    logic [WIDTH-1:0] blk_sum1;
    logic [NB-1:0]    blk_c0;
    logic [NB-1:0]    blk_c1;

    // Stage 1 state
    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_sum0_reg;
    logic [WIDTH-1:0] s1_sum1_reg;
    logic [NB-1:0]    s1_c0_reg;
    logic [NB-1:0]    s1_c1_reg;

    // Stage 2 (output) state
    logic             out_valid_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;

    // Stage 2 resolution
    logic [WIDTH-1:0] res_sum;
    logic [NB:0]      carry_chain;

    // Handshake: each stage moves when it is empty or its successor moves.
    logic s2_advance;
    logic s1_advance;

    assign s2_advance = !out_valid_reg || out_ready;
    assign s1_advance = s2_advance;
    assign in_ready   = !s1_valid_reg || s1_advance;

    // Block 0 sees the real carry-in on both paths, so its two results are
    // identical and the mux chain can start from a constant 0 select.
    assign carry_chain[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_blk
            csa_block #(
                .BLOCK(BLOCK)
            ) u_blk (
                .a    (a[gi*BLOCK +: BLOCK]),
                .b    (b[gi*BLOCK +: BLOCK]),
                .cin0 ((gi == 0) ? cin : 1'b0),
                .cin1 ((gi == 0) ? cin : 1'b1),
                .sum0 (blk_sum0[gi*BLOCK +: BLOCK]),
                .sum1 (blk_sum1[gi*BLOCK +: BLOCK]),
                .c0   (blk_c0[gi]),
                .c1   (blk_c1[gi])
            );

            assign res_sum[gi*BLOCK +: BLOCK] = carry_chain[gi] ? s1_sum1_reg[gi*BLOCK +: BLOCK]
                                                                : s1_sum0_reg[gi*BLOCK +: BLOCK];
            assign carry_chain[gi+1]          = carry_chain[gi] ? s1_c1_reg[gi] : s1_c0_reg[gi];
        end
    endgenerate

    // Stage 1: capture both candidate results of every block on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_sum0_reg  <= '0;
            s1_sum1_reg  <= '0;
            s1_c0_reg    <= '0;
            s1_c1_reg    <= '0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_sum0_reg <= blk_sum0;
                s1_sum1_reg <= blk_sum1;
                s1_c0_reg   <= blk_c0;
                s1_c1_reg   <= blk_c1;
            end
        end
    end

    // Stage 2: register the resolved sum and final carry; hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
        end else if (s2_advance) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                sum_reg  <= res_sum;
                cout_reg <= carry_chain[NB];
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;

`ifdef CSA_OVF_EN
    // Operand sign bits travel with stage 1 so overflow lines up with sum.
    logic s1_a_msb_reg;
    logic s1_b_msb_reg;
    logic ovf_reg;

    // Stage 1 side-band: operand sign bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a_msb_reg <= 1'b0;
            s1_b_msb_reg <= 1'b0;
        end else if (in_ready && in_valid) begin
            s1_a_msb_reg <= a[WIDTH-1];
            s1_b_msb_reg <= b[WIDTH-1];
        end
    end

    // Stage 2 side-band: same-sign operands producing a different-sign sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (s2_advance && s1_valid_reg) begin
            ovf_reg <= (s1_a_msb_reg == s1_b_msb_reg) && (res_sum[WIDTH-1] != s1_a_msb_reg);
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_pipelined_csa_adder.sv
// Directed and random checks for pipelined_csa_adder (32/4, 16/4 and 8/8).
module tb_pipelined_csa_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- 32-bit DUT (directed tests) ----------------
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
`ifdef CSA_OVF_EN
    logic        ovf;
`endif

    pipelined_csa_adder #(.WIDTH(32), .BLOCK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CSA_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // ---------------- random-stream DUTs ----------------
    logic        rst_r;

    logic        r16_in_valid, r16_in_ready, r16_cin, r16_out_valid, r16_out_ready, r16_cout;
    logic [15:0] r16_a, r16_b, r16_sum;
`ifdef CSA_OVF_EN
    logic        r16_ovf;
`endif

    pipelined_csa_adder #(.WIDTH(16), .BLOCK(4)) dut16 (
        .clk       (clk),
        .rst_n     (rst_r),
        .in_valid  (r16_in_valid),
        .in_ready  (r16_in_ready),
        .a         (r16_a),
        .b         (r16_b),
        .cin       (r16_cin),
        .out_valid (r16_out_valid),
        .out_ready (r16_out_ready),
        .sum       (r16_sum),
        .cout      (r16_cout)
`ifdef CSA_OVF_EN
        ,
        .ovf       (r16_ovf)
`endif
    );

    logic        r8_in_valid, r8_in_ready, r8_cin, r8_out_valid, r8_out_ready, r8_cout;
    logic [7:0]  r8_a, r8_b, r8_sum;
`ifdef CSA_OVF_EN
    logic        r8_ovf;
`endif

    pipelined_csa_adder #(.WIDTH(8), .BLOCK(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_r),
        .in_valid  (r8_in_valid),
        .in_ready  (r8_in_ready),
        .a         (r8_a),
        .b         (r8_b),
        .cin       (r8_cin),
        .out_valid (r8_out_valid),
        .out_ready (r8_out_ready),
        .sum       (r8_sum),
        .cout      (r8_cout)
`ifdef CSA_OVF_EN
        ,
        .ovf       (r8_ovf)
`endif
    );

    localparam int N_RANDOM    = 10000;
    localparam int CYCLE_LIMIT = 40000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    // Random stream on the 16-bit instance; one line per delivered result only on error.
    task automatic run_stream16();
        logic [16:0] exp_q[$];
        logic [15:0] cur_a, cur_b;
        logic        cur_c;
        int          sent   = 0;
        int          recv   = 0;
        int          cycles = 0;
        cur_a = 16'($urandom);
        cur_b = 16'($urandom);
        cur_c = 1'($urandom);
        while (recv < N_RANDOM && cycles < CYCLE_LIMIT) begin
            @(negedge clk);
            cycles++;
            r16_in_valid  = (sent < N_RANDOM) && ($urandom_range(0, 3) != 0);
            r16_a         = cur_a;
            r16_b         = cur_b;
            r16_cin       = cur_c;
            r16_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (r16_out_valid && r16_out_ready) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL r16 spurious: got result 0x%0h, expected none", {r16_cout, r16_sum});
                end else begin
                    check("r16 result", 64'({r16_cout, r16_sum}), 64'(exp_q.pop_front()));
                end
                recv++;
            end
            if (r16_in_valid && r16_in_ready) begin
                exp_q.push_back(17'(cur_a) + 17'(cur_b) + 17'(cur_c));
                sent++;
                cur_a = 16'($urandom);
                cur_b = 16'($urandom);
                cur_c = 1'($urandom);
            end
        end
        check("r16 received", 64'(recv), 64'(N_RANDOM));
        $display("[TB] stream W16/B4: sent %0d, received %0d in %0d cycles", sent, recv, cycles);
    endtask

    // Random stream on the 8-bit single-block instance.
    task automatic run_stream8();
        logic [8:0] exp_q[$];
        logic [7:0] cur_a, cur_b;
        logic       cur_c;
        int         sent   = 0;
        int         recv   = 0;
        int         cycles = 0;
        cur_a = 8'($urandom);
        cur_b = 8'($urandom);
        cur_c = 1'($urandom);
        while (recv < N_RANDOM && cycles < CYCLE_LIMIT) begin
            @(negedge clk);
            cycles++;
            r8_in_valid  = (sent < N_RANDOM) && ($urandom_range(0, 3) != 0);
            r8_a         = cur_a;
            r8_b         = cur_b;
            r8_cin       = cur_c;
            r8_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (r8_out_valid && r8_out_ready) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL r8 spurious: got result 0x%0h, expected none", {r8_cout, r8_sum});
                end else begin
                    check("r8 result", 64'({r8_cout, r8_sum}), 64'(exp_q.pop_front()));
                end
                recv++;
            end
            if (r8_in_valid && r8_in_ready) begin
                exp_q.push_back(9'(cur_a) + 9'(cur_b) + 9'(cur_c));
                sent++;
                cur_a = 8'($urandom);
                cur_b = 8'($urandom);
                cur_c = 1'($urandom);
            end
        end
        check("r8 received", 64'(recv), 64'(N_RANDOM));
        $display("[TB] stream W8/B8: sent %0d, received %0d in %0d cycles", sent, recv, cycles);
    endtask

    initial begin
        logic [32:0] bp_exp [3];
        int          idx;
        int          seen;

        //          a             b             cin   sum           cout  ovf
        vecs[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        vecs[7] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
        vecs[8] = '{32'h0FFF_FFFF, 32'h0000_0000, 1'b1, 32'h1000_0000, 1'b0, 1'b0};
        vecs[9] = '{32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

        rst_n = 1'b0; rst_r = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        r16_in_valid = 1'b0; r16_a = '0; r16_b = '0; r16_cin = 1'b0; r16_out_ready = 1'b0;
        r8_in_valid  = 1'b0; r8_a  = '0; r8_b  = '0; r8_cin  = 1'b0; r8_out_ready  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset sum", 64'(sum), 64'(0));
        check("reset cout", 64'(cout), 64'(0));
`ifdef CSA_OVF_EN
        check("reset ovf", 64'(ovf), 64'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        rst_r = 1'b1;
        #1;
        check("in_ready after reset", 64'(in_ready), 64'(1));

        // Table-driven single transfers with latency check
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(1));
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check($sformatf("vec%0d early out_valid", i), 64'(out_valid), 64'(0));
            @(negedge clk);
            #1;
            check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(1));
            check($sformatf("vec%0d sum", i), 64'(sum), 64'(vecs[i].exp_sum));
            check($sformatf("vec%0d cout", i), 64'(cout), 64'(vecs[i].exp_cout));
`ifdef CSA_OVF_EN
            check($sformatf("vec%0d ovf", i), 64'(ovf), 64'(vecs[i].exp_ovf));
`endif
            @(negedge clk);
            #1;
            check($sformatf("vec%0d drained", i), 64'(out_valid), 64'(0));
            $display("[TB] vec%0d a=0x%08h b=0x%08h cin=%0d -> sum=0x%08h cout=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].cin, sum, cout);
        end

        // Backpressure: three back-to-back inputs with the consumer stalled
        bp_exp[0] = 33'h0_0000_001E;
        bp_exp[1] = 33'h1_0000_0000;
        bp_exp[2] = 33'h0_0000_0301;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        a = 32'd10; b = 32'd20; cin = 1'b0;
        #1;
        check("bp accept0 in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0;
        #1;
        check("bp accept1 in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        a = 32'h0000_0100; b = 32'h0000_0200; cin = 1'b1;
        #1;
        check("bp full in_ready", 64'(in_ready), 64'(0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("bp hold%0d in_ready", c), 64'(in_ready), 64'(0));
            check($sformatf("bp hold%0d out_valid", c), 64'(out_valid), 64'(1));
            check($sformatf("bp hold%0d result", c), 64'({cout, sum}), 64'(bp_exp[0]));
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 64'(in_ready), 64'(1));
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) begin
                if (idx < 3) begin
                    check($sformatf("bp result%0d", idx), 64'({cout, sum}), 64'(bp_exp[idx]));
                    $display("[TB] bp result%0d = 0x%09h", idx, {cout, sum});
                end else begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL bp extra result: got 0x%0h, expected none", {cout, sum});
                end
                idx++;
            end
            @(negedge clk);
            in_valid = 1'b0;
            #1;
        end
        check("bp result count", 64'(idx), 64'(3));

        // Reset with two transfers in flight
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        a = 32'd5; b = 32'd6; cin = 1'b0;
        @(negedge clk);
        a = 32'd7; b = 32'd8; cin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("mid rst in flight", 64'(out_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst out_valid", 64'(out_valid), 64'(0));
        check("mid rst sum", 64'(sum), 64'(0));
        check("mid rst cout", 64'(cout), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("mid rst in_ready", 64'(in_ready), 64'(1));
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("no result after rst", 64'(seen), 64'(0));
        $display("[TB] reset mid-flight: results seen after release = %0d", seen);

        // Random valid/ready streams on the narrow instances
        fork
            run_stream16();
            run_stream8();
        join

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
